nist_selftest_source: RTL and testbench

Self-test stimulus source for the NIST SP 800-22 randomness tester. It sits between the ALFSR digitized output and the tester's bit input. In normal operation it passes live random bits through. On request it drives four known bit patterns, one test window each, captures the tester's four error flags after each window, and reports per-pattern pass/fail.

---
 rtl/nist_selftest_pkg.sv | 28 ++
 rtl/nist_selftest_if.sv | 19 +
 rtl/nist_pattern_gen.sv | 51 +++++
 rtl/nist_selftest_source.sv | 118 +++++++++++
 tb/tb_nist_selftest_source.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/nist_selftest_pkg.sv
// Shared types and constants for the NIST self-test stimulus source.
// Macro NIST_SELFTEST_LFSR_EN adds the fourth (LFSR) pattern.
package nist_selftest_pkg;

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_SETTLE, S_CAPTURE} state_t;
   typedef logic [1:0] pat_t;

   localparam int WINDOW_LEN_DEF = 128;
   localparam int SETTLE_CYC_DEF = 4;

   // Expected tester flags per pattern, indexed by pattern number.
   localparam logic [3:0][3:0] EXP_MASK = {4'b0000, 4'b1100, 4'b1011, 4'b1011};

   // Fibonacci taps 16,14,13,11 seen from the right-shifting register: bits 0,2,3,5.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

`ifdef NIST_SELFTEST_LFSR_EN
   localparam pat_t LAST_PAT = 2'd3;
`else
   localparam pat_t LAST_PAT = 2'd2;
`endif

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/nist_selftest_if.sv
// Bundle of the stimulus source's data/handshake signals toward ALFSR and tester.
interface nist_selftest_if;
   import nist_selftest_pkg::*;

   logic       start;
   logic       rng_bit;
   logic [3:0] nist_err;
   logic       rnd_out;
   logic       nist_rst;
   logic       busy;
   logic       done;
   logic [3:0] result;
   pat_t       pattern;

   modport master (input start, rng_bit, nist_err,
                   output rnd_out, nist_rst, busy, done, result, pattern);
   modport slave  (output start, rng_bit, nist_err,
                   input rnd_out, nist_rst, busy, done, result, pattern);
endinterface

// File: rtl/nist_pattern_gen.sv
// Known-pattern bit generator. Presents bit 0 while load is high, then one new
// bit per advance. LFSR present only with NIST_SELFTEST_LFSR_EN.
module nist_pattern_gen
   import nist_selftest_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  pat_t pat_i,
   input  logic load_i,
   input  logic adv_i,
   output logic bit_o
);

   logic tog_q;
   logic tog_bit;
   logic lfsr_bit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         tog_q <= 1'b0;
      else if (load_i) tog_q <= 1'b1;
      else if (adv_i)  tog_q <= ~tog_q;
   end

   assign tog_bit = load_i ? 1'b0 : tog_q;

`ifdef NIST_SELFTEST_LFSR_EN
   logic [15:0] lfsr_q;

   // Registers always hold the bit after the one being presented.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         lfsr_q <= LFSR_SEED;
      else if (load_i) lfsr_q <= lfsr_step(LFSR_SEED);
      else if (adv_i)  lfsr_q <= lfsr_step(lfsr_q);
   end

   assign lfsr_bit = load_i ? LFSR_SEED[0] : lfsr_q[0];
`else
   assign lfsr_bit = 1'b0;
`endif

   always_comb begin
      bit_o = 1'b0;
      case (pat_i)
         2'd0:    bit_o = 1'b0;
         2'd1:    bit_o = 1'b1;
         2'd2:    bit_o = tog_bit;
         default: bit_o = lfsr_bit;
      endcase
   end

endmodule

// File: rtl/nist_selftest_source.sv
// Self-test source: passes live RNG bits, or on start drives known patterns to the
// NIST tester and grades its flags. NIST_SELFTEST_LFSR_EN enables pattern 3.
module nist_selftest_source
   import nist_selftest_pkg::*;
#(
   parameter int WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
)(
   input logic             clk,
   input logic             rst,
   nist_selftest_if.master bus
);

   localparam int CNT_MAX = (WINDOW_LEN > SETTLE_CYC) ? WINDOW_LEN : SETTLE_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RUN_LAST    = CW'(WINDOW_LEN - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   pat_t          pat_q, pat_d;
   logic [3:0]    res_q, res_d;
   logic          rnd_q, rnd_d;
   logic          done_q, done_d;
   logic          gen_bit, gen_load, gen_adv;

   nist_pattern_gen u_gen (
      .clk    (clk),
      .rst    (rst),
      .pat_i  (pat_q),
      .load_i (gen_load),
      .adv_i  (gen_adv),
      .bit_o  (gen_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pat_q   <= '0;
         res_q   <= '0;
         rnd_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         res_q   <= res_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pat_d    = pat_q;
      res_d    = res_q;
      rnd_d    = 1'b0;
      done_d   = 1'b0;
      gen_load = 1'b0;
      gen_adv  = 1'b0;
      case (state_q)
         S_IDLE: begin
            rnd_d = bus.rng_bit;
            // done_q marks the first idle cycle; a start there belongs to the old run.
            if (bus.start && !done_q) begin
               pat_d   = '0;
               res_d   = '0;
               state_d = S_PRIME;
            end
         end
         S_PRIME: begin
            gen_load = 1'b1;
            cnt_d    = '0;
            rnd_d    = gen_bit;
            state_d  = S_RUN;
         end
         S_RUN: begin
            gen_adv = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == RUN_LAST) begin
               cnt_d   = '0;
               state_d = S_SETTLE;
            end else begin
               rnd_d = gen_bit;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            res_d[pat_q] = (bus.nist_err == EXP_MASK[pat_q]);
            if (pat_q == LAST_PAT) begin
               pat_d   = '0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               pat_d   = pat_q + 1'b1;
               state_d = S_PRIME;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.rnd_out  = rnd_q;
   assign bus.nist_rst = (state_q == S_PRIME);
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q;
   assign bus.result   = res_q;
   assign bus.pattern  = pat_q;

endmodule

// File: tb/tb_nist_selftest_source.sv
// Randomized scoreboard bench for nist_selftest_source.
module tb_nist_selftest_source;

   localparam int W  = 128;
   localparam int S  = 4;
   localparam int WL = W + S;
`ifdef NIST_SELFTEST_LFSR_EN
   localparam int NP = 4;
`else
   localparam int NP = 3;
`endif
   localparam logic [3:0] EXP [4] = '{4'b1011, 4'b1011, 4'b1100, 4'b0000};

   typedef struct { logic [3:0] res; int at; } run_t;
   typedef struct { int p; logic [3:0] err; logic [WL-1:0] bits; } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   run_t runq[$];
   win_t winq[$];

   nist_selftest_if bus();

   nist_selftest_source #(.WINDOW_LEN(W), .SETTLE_CYC(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Expected tester-visible stream for one window: pattern bits, then settle zeros.
   function automatic logic [WL-1:0] exp_win(input int p);
      logic [WL-1:0] v;
      logic [15:0]   seed;
      bit            s [W];
      v    = '0;
      seed = 16'hACE1;
      for (int i = 0; i < W; i++) begin
         case (p)
            0:       s[i] = 1'b0;
            1:       s[i] = 1'b1;
            2:       s[i] = (i % 2) == 1;
            default: s[i] = (i < 16) ? seed[i] : (s[i-16] ^ s[i-14] ^ s[i-13] ^ s[i-11]);
         endcase
         v[i] = s[i];
      end
      return v;
   endfunction

   // Tester model + window monitor: drives the flags and checks each window's bits.
   win_t          cur;
   logic [WL-1:0] wbits;
   int            wpos;
   bit            won;
   always @(negedge clk) begin
      if (rst) begin
         won          = 1'b0;
         bus.nist_err = 4'h0;
      end else begin
         if (won) begin
            wbits[wpos] = bus.rnd_out;
            wpos++;
            if (wpos == WL) begin
               won = 1'b0;
               total++;
               if (wbits !== cur.bits) begin
                  bad++;
                  $display("FAIL window p%0d: got %h want %h", cur.p, wbits, cur.bits);
               end
            end
         end
         if (bus.nist_rst) begin
            if (winq.size() == 0) begin
               total++; bad++;
               $display("FAIL nist_rst unexpected: got 1 want 0 (cyc %0d)", cyc);
            end else begin
               cur          = winq.pop_front();
               bus.nist_err = cur.err;
               chk("pattern_index", 32'(bus.pattern), 32'(cur.p));
               won   = 1'b1;
               wpos  = 0;
               wbits = '0;
            end
         end
      end
   end

   // Run-completion monitor.
   run_t r;
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (runq.size() == 0) begin
            total++; bad++;
            $display("FAIL done unexpected: got 1 want 0 (cyc %0d)", cyc);
         end else begin
            r = runq.pop_front();
            chk("result", 32'(bus.result), 32'(r.res));
            chk("done_cycle", cyc, r.at);
            chk("busy_at_done", 32'(bus.busy), 0);
            chk("pattern_at_done", 32'(bus.pattern), 0);
         end
      end
   end

   // mode 0: tester returns exact masks, 1: all zeros, 2: random mix.
   task automatic issue(input int mode);
      run_t rr;
      win_t w;
      rr.res = '0;
      for (int p = 0; p < NP; p++) begin
         case (mode)
            0:       w.err = EXP[p];
            1:       w.err = 4'h0;
            default: w.err = ($urandom_range(0, 1) == 1) ? EXP[p] : 4'($urandom);
         endcase
         w.p    = p;
         w.bits = exp_win(p);
         rr.res[p] = (w.err == EXP[p]);
         winq.push_back(w);
      end
      @(negedge clk);
      chk("busy_before_start", 32'(bus.busy), 0);
      bus.start = 1'b1;
      rr.at = cyc + NP * (W + S + 2) + 1;
      runq.push_back(rr);
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_rise", 32'(bus.busy), 1);
      chk("nist_rst_prime", 32'(bus.nist_rst), 1);
   endtask

   task automatic run(input int mode, input bit extra, input bit start_at_done);
      bit seen;
      seen = 1'b0;
      issue(mode);
      for (int k = 2; k < 3000 && !seen; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
         else bus.start = extra && (k == 10 || k == 300);
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL run timeout: got no done want done");
      end
      if (start_at_done && seen) begin
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         chk("start_at_done_ignored", 32'(bus.busy), 0);
      end
      repeat (3) @(negedge clk);
      chk("idle_after_run", 32'(bus.busy), 0);
      chk("runs_drained", runq.size(), 0);
      chk("windows_drained", winq.size(), 0);
   endtask

   task automatic passthru(input int n);
      logic [3:0] dir;
      logic       v;
      dir = 4'b1101;
      for (int i = 0; i < n; i++) begin
         v = (i < 4) ? dir[i] : 1'($urandom);
         bus.rng_bit = v;
         @(negedge clk);
         chk("passthru", 32'(bus.rnd_out), 32'(v));
         chk("nist_rst_idle", 32'(bus.nist_rst), 0);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_rnd_out", 32'(bus.rnd_out), 0);
      chk("rst_nist_rst", 32'(bus.nist_rst), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_result", 32'(bus.result), 0);
      chk("rst_pattern", 32'(bus.pattern), 0);
   endtask

   task automatic reset_mid();
      int n;
      issue(0);
      n = 0;
      while (bus.pattern != 2'd1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_p1", 32'(bus.pattern), 1);
      repeat (20) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_vals();
      runq.delete();
      winq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 32'(bus.busy), 0);
   endtask

   initial begin
      bus.start   = 1'b0;
      bus.rng_bit = 1'b0;
      #1 check_reset_vals();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      passthru(12);
      run(0, 1'b0, 1'b0);
      passthru(6);
      run(1, 1'b0, 1'b1);
      run(2, 1'b1, 1'b0);
      reset_mid();
      passthru(8);
      run(2, 1'b0, 1'b0);
      passthru(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
